// File: rtl/epmp_bus_pkg.sv
// Shared constants for the EPMP bus UART: register map, STATUS layout, FSM encodings.
// RX encodings exist only when EPMP_UART_RX_EN is defined.
package epmp_bus_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int ST_RX_OVR  = 3;
  localparam int ST_RX_FERR = 4;
  localparam int ST_TX_DROP = 5;
  localparam int CTRL_TX_IE = 0;

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

`ifdef EPMP_UART_RX_EN
  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;
`endif

  typedef struct packed {
    logic tx_drop;
    logic rx_ferr;
    logic rx_ovr;
    logic rx_valid;
    logic tx_empty;
    logic tx_full;
  } status_t;

  function automatic logic [7:0] pack_status(status_t s);
    return {2'b00, s};
  endfunction

endpackage

// File: rtl/epmp_uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter; first-word fall-through on dout.
// A push into a full FIFO is accepted only when a pop happens the same cycle.
module epmp_uart_tx_fifo
  import epmp_bus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/epmp_bus_uart.sv
// 8N1 UART on the EPMP external bus: 4-byte register window, TX FIFO, 1-byte RX.
// Receiver is built only when EPMP_UART_RX_EN is defined.
module epmp_bus_uart
  import epmp_bus_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR    = 16'hFF00,
  parameter int          CLKS_PER_BIT = 868,
  parameter int          TX_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic [15:0] A,
  inout  wire  [7:0]  D,
  input  logic        Read,
  input  logic        Write,
  output logic        TxD,
  input  logic        RxD,
  output logic        Irq
);

  localparam int            TW     = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] BIT_LD = TW'(CLKS_PER_BIT - 1);

  logic       hit;
  logic [1:0] offs;
  logic       write_q;
  logic       wr_stb;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       tx_ie;
  logic       tx_drop;
  logic       tx_empty;

  logic       rx_valid;
  logic       rx_ovr;
  logic       rx_ferr;
  logic [7:0] rx_data;

  logic                        fifo_push;
  logic                        fifo_pop;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [7:0]                  fifo_dout;
  logic [$clog2(TX_DEPTH):0]   fifo_count;

  logic [1:0]    tx_state;
  logic [TW-1:0] tx_tmr;
  logic [2:0]    tx_cnt;
  logic [7:0]    tx_shift;

  status_t st;

  assign hit     = A[15:2] == BASE_ADDR[15:2];
  assign offs    = A[1:0];
  assign wr_data = D;
  assign wr_stb  = Write && !write_q && hit;
  assign D       = (Read && hit) ? rd_data : 8'hzz;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) write_q <= 1'b0;
    else        write_q <= Write;
  end

  assign st.tx_full  = fifo_full;
  assign st.tx_empty = tx_empty;
  assign st.rx_valid = rx_valid;
  assign st.rx_ovr   = rx_ovr;
  assign st.rx_ferr  = rx_ferr;
  assign st.tx_drop  = tx_drop;

  always_comb begin
    rd_data = 8'h00;
    unique case (1'b1)
      offs == REG_DATA:   rd_data = rx_data;
      offs == REG_STATUS: rd_data = pack_status(st);
      offs == REG_CTRL:   rd_data = {7'd0, tx_ie};
      offs == REG_RSVD:   rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      tx_ie   <= 1'b0;
      tx_drop <= 1'b0;
    end else begin
      if (wr_stb && offs == REG_CTRL)
        tx_ie <= wr_data[CTRL_TX_IE];
      if (wr_stb && offs == REG_STATUS && wr_data[ST_TX_DROP])
        tx_drop <= 1'b0;
      if (fifo_push && fifo_full && !fifo_pop)
        tx_drop <= 1'b1;
    end
  end

  assign fifo_push = wr_stb && offs == REG_DATA;
  assign fifo_pop  = !fifo_empty &&
                     (tx_state == TX_IDLE ||
                      (tx_state == TX_STOP && tx_tmr == '0));
  assign tx_empty  = fifo_count == '0 && tx_state == TX_IDLE;

  epmp_uart_tx_fifo #(
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst_n (Reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (wr_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // STOP chains straight into START when more data is queued.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      tx_state <= TX_IDLE;
      tx_tmr   <= '0;
      tx_cnt   <= '0;
      tx_shift <= '0;
    end else begin
      unique case (tx_state)
        TX_IDLE: begin
          if (fifo_pop) begin
            tx_shift <= fifo_dout;
            tx_tmr   <= BIT_LD;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_tmr == '0) begin
            tx_tmr   <= BIT_LD;
            tx_cnt   <= '0;
            tx_state <= TX_DATA;
          end else begin
            tx_tmr <= tx_tmr - 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_tmr == '0) begin
            tx_tmr   <= BIT_LD;
            tx_shift <= {1'b0, tx_shift[7:1]};
            if (tx_cnt == 3'd7) tx_state <= TX_STOP;
            else                tx_cnt   <= tx_cnt + 1'b1;
          end else begin
            tx_tmr <= tx_tmr - 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_tmr == '0) begin
            if (fifo_pop) begin
              tx_shift <= fifo_dout;
              tx_tmr   <= BIT_LD;
              tx_state <= TX_START;
            end else begin
              tx_state <= TX_IDLE;
            end
          end else begin
            tx_tmr <= tx_tmr - 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  always_comb begin
    TxD = 1'b1;
    unique case (tx_state)
      TX_START: TxD = 1'b0;
      TX_DATA:  TxD = tx_shift[0];
      default:  TxD = 1'b1;
    endcase
  end

`ifdef EPMP_UART_RX_EN
  localparam logic [TW-1:0] HALF_LD = TW'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]    rx_sync;
  logic          rxd_s;
  logic [1:0]    rx_state;
  logic [TW-1:0] rx_tmr;
  logic [2:0]    rx_cnt;
  logic [7:0]    rx_shift;
  logic          rx_done;
  logic          pop_pend;
  logic          rx_pop;

  assign rxd_s   = rx_sync[1];
  assign rx_done = rx_state == RX_STOP && rx_tmr == '0;
  assign rx_pop  = pop_pend && !Read;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) rx_sync <= 2'b11;
    else        rx_sync <= {rx_sync[0], RxD};
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      rx_state <= RX_IDLE;
      rx_tmr   <= '0;
      rx_cnt   <= '0;
      rx_shift <= '0;
    end else begin
      unique case (rx_state)
        RX_IDLE: begin
          if (!rxd_s) begin
            rx_tmr   <= HALF_LD;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_tmr != '0) begin
            rx_tmr <= rx_tmr - 1'b1;
          end else if (rxd_s) begin
            rx_state <= RX_IDLE;
          end else begin
            rx_tmr   <= BIT_LD;
            rx_cnt   <= '0;
            rx_state <= RX_DATA;
          end
        end
        RX_DATA: begin
          if (rx_tmr == '0) begin
            rx_tmr   <= BIT_LD;
            rx_shift <= {rxd_s, rx_shift[7:1]};
            if (rx_cnt == 3'd7) rx_state <= RX_STOP;
            else                rx_cnt   <= rx_cnt + 1'b1;
          end else begin
            rx_tmr <= rx_tmr - 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_tmr == '0) rx_state <= RX_IDLE;
          else              rx_tmr   <= rx_tmr - 1'b1;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // A pop takes effect when the DATA read strobe drops, and beats a same-cycle overrun.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      pop_pend <= 1'b0;
      rx_valid <= 1'b0;
      rx_ovr   <= 1'b0;
      rx_ferr  <= 1'b0;
      rx_data  <= '0;
    end else begin
      if (Read && hit && offs == REG_DATA) pop_pend <= 1'b1;
      else if (!Read)                      pop_pend <= 1'b0;
      if (wr_stb && offs == REG_STATUS) begin
        if (wr_data[ST_RX_OVR])  rx_ovr  <= 1'b0;
        if (wr_data[ST_RX_FERR]) rx_ferr <= 1'b0;
      end
      if (rx_done) begin
        if (!rxd_s) rx_ferr <= 1'b1;
        if (rx_valid && !rx_pop) begin
          rx_ovr <= 1'b1;
        end else begin
          rx_data  <= rx_shift;
          rx_valid <= 1'b1;
        end
      end else if (rx_pop) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign Irq = rx_valid | (tx_empty & tx_ie);
`else
  logic unused_rxd;

  assign unused_rxd = RxD;
  assign rx_valid   = 1'b0;
  assign rx_ovr     = 1'b0;
  assign rx_ferr    = 1'b0;
  assign rx_data    = 8'h00;
  assign Irq        = tx_empty & tx_ie;
`endif

endmodule

// File: tb/tb_epmp_bus_uart.sv
// Self-checking bench for epmp_bus_uart: TX frame scoreboard, bus map, RX when enabled.
// RX scenarios are compiled in with EPMP_UART_RX_EN, otherwise the RX-absent behaviour is checked.
module tb_epmp_bus_uart;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] A = 16'h0000;
  logic        Read = 1'b0;
  logic        Write = 1'b0;
  logic        RxD = 1'b1;
  logic [7:0]  d_drv = 8'h00;
  logic        d_en = 1'b0;
  wire  [7:0]  D;
  wire         TxD;
  wire         Irq;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic [8:0] exp_tx[$];
  logic [8:0] got_tx[$];
  int         got_t[$];
  logic [7:0] exp_rx[$];

  assign D = d_en ? d_drv : 8'hzz;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  epmp_bus_uart #(
    .BASE_ADDR    (16'hFF00),
    .CLKS_PER_BIT (CPB),
    .TX_DEPTH     (4)
  ) dut (
    .clk   (clk),
    .Reset (rst_n),
    .A     (A),
    .D     (D),
    .Read  (Read),
    .Write (Write),
    .TxD   (TxD),
    .RxD   (RxD),
    .Irq   (Irq)
  );

  // Serial monitor: samples each bit mid-cell, records {stop, data} and start cycle.
  initial begin
    logic [8:0] f;
    int t;
    forever begin
      @(negedge clk);
      if (rst_n && TxD === 1'b0) begin
        t = cyc;
        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
          repeat (CPB) @(negedge clk);
          f[i] = TxD;
        end
        got_tx.push_back(f);
        got_t.push_back(t);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d,
                           input int hold = 1);
    @(negedge clk);
    A = a; d_drv = d; d_en = 1'b1; Write = 1'b1;
    repeat (hold) @(negedge clk);
    Write = 1'b0; d_en = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
    @(negedge clk);
    A = a; Read = 1'b1;
    #1 d = D;
    @(negedge clk);
    Read = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (got_tx.size() >= n) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(negedge clk);
    RxD = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RxD = b[i];
      repeat (CPB) @(negedge clk);
    end
    RxD = stop;
    repeat (CPB) @(negedge clk);
    RxD = 1'b1;
  endtask

  task automatic test_reset();
    logic [7:0] r;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (TxD !== 1'b1) begin
      n_err++; $display("FAIL reset_txd: got %b want 1", TxD);
    end
    n_cmp++;
    if (Irq !== 1'b0) begin
      n_err++; $display("FAIL reset_irq: got %b want 0", Irq);
    end
    rst_n = 1'b1;
    bus_read(16'hFF01, r);
    n_cmp++;
    if (r !== 8'h02) begin
      n_err++; $display("FAIL reset_status: got %h want 02", r);
    end
    bus_read(16'hFF02, r);
    n_cmp++;
    if (r !== 8'h00) begin
      n_err++; $display("FAIL reset_ctrl: got %h want 00", r);
    end
  endtask

  task automatic test_tx();
    logic [7:0] r;
    logic [8:0] e;
    logic [8:0] g;
    bit ok;
    exp_tx.push_back({1'b1, 8'hA5});
    bus_write(16'hFF00, 8'hA5);
    wait_frames(1, 80, ok);
    n_cmp++;
    if (!ok) begin
      n_err++; $display("FAIL tx_timeout: got %0d frames want 1", got_tx.size());
    end else begin
      e = exp_tx.pop_front(); g = got_tx.pop_front(); void'(got_t.pop_front());
      n_cmp++;
      if (g !== e) begin
        n_err++; $display("FAIL tx_frame: got %h want %h", g, e);
      end
    end
    repeat (4) @(negedge clk);
    bus_read(16'hFF01, r);
    n_cmp++;
    if (r !== 8'h02) begin
      n_err++; $display("FAIL tx_status_done: got %h want 02", r);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] r;
    logic [8:0] e;
    logic [8:0] g;
    int t;
    int t_prev;
    bit ok;
    for (int i = 1; i <= 6; i++) begin
      if (i <= 5) exp_tx.push_back({1'b1, 8'(i)});
      bus_write(16'hFF00, 8'(i));
    end
    bus_read(16'hFF01, r);
    n_cmp++;
    if (r !== 8'h21) begin
      n_err++; $display("FAIL drop_status: got %h want 21", r);
    end
    bus_write(16'hFF01, 8'h20);
    bus_read(16'hFF01, r);
    n_cmp++;
    if (r !== 8'h01) begin
      n_err++; $display("FAIL drop_clear: got %h want 01", r);
    end
    wait_frames(5, 300, ok);
    n_cmp++;
    if (!ok) begin
      n_err++; $display("FAIL b2b_timeout: got %0d frames want 5", got_tx.size());
    end else begin
      t_prev = 0;
      for (int i = 0; i < 5; i++) begin
        e = exp_tx.pop_front(); g = got_tx.pop_front(); t = got_t.pop_front();
        n_cmp++;
        if (g !== e) begin
          n_err++; $display("FAIL b2b_frame%0d: got %h want %h", i, g, e);
        end
        if (i > 0) begin
          n_cmp++;
          if (t - t_prev !== 10 * CPB) begin
            n_err++; $display("FAIL b2b_gap%0d: got %0d want %0d", i, t - t_prev, 10 * CPB);
          end
        end
        t_prev = t;
      end
    end
    repeat (4) @(negedge clk);
    bus_read(16'hFF01, r);
    n_cmp++;
    if (r !== 8'h02) begin
      n_err++; $display("FAIL b2b_status_done: got %h want 02", r);
    end
  endtask

  task automatic test_multi_write();
    logic [7:0] r;
    logic [8:0] e;
    logic [8:0] g;
    bit ok;
    exp_tx.push_back({1'b1, 8'h3C});
    bus_write(16'hFF00, 8'h3C, 3);
    wait_frames(1, 80, ok);
    n_cmp++;
    if (!ok) begin
      n_err++; $display("FAIL mw_timeout: got %0d frames want 1", got_tx.size());
    end else begin
      e = exp_tx.pop_front(); g = got_tx.pop_front(); void'(got_t.pop_front());
      n_cmp++;
      if (g !== e) begin
        n_err++; $display("FAIL mw_frame: got %h want %h", g, e);
      end
    end
    repeat (60) @(negedge clk);
    n_cmp++;
    if (got_tx.size() !== 0) begin
      n_err++; $display("FAIL mw_extra_frames: got %0d want 0", got_tx.size());
    end
    bus_read(16'hFF01, r);
    n_cmp++;
    if (r !== 8'h02) begin
      n_err++; $display("FAIL mw_status: got %h want 02", r);
    end
  endtask

  task automatic test_ctrl_irq();
    logic [7:0] r;
    bus_write(16'hFF02, 8'hFF);
    bus_read(16'hFF02, r);
    n_cmp++;
    if (r !== 8'h01) begin
      n_err++; $display("FAIL ctrl_read: got %h want 01", r);
    end
    n_cmp++;
    if (Irq !== 1'b1) begin
      n_err++; $display("FAIL irq_tx_empty: got %b want 1", Irq);
    end
    bus_write(16'hFF03, 8'hFF);
    bus_read(16'hFF03, r);
    n_cmp++;
    if (r !== 8'h00) begin
      n_err++; $display("FAIL rsvd_read: got %h want 00", r);
    end
    bus_write(16'hFE02, 8'h00);
    bus_read(16'hFF02, r);
    n_cmp++;
    if (r !== 8'h01) begin
      n_err++; $display("FAIL miss_write: got %h want 01", r);
    end
    bus_write(16'hFF02, 8'h00);
    @(negedge clk);
    n_cmp++;
    if (Irq !== 1'b0) begin
      n_err++; $display("FAIL irq_off: got %b want 0", Irq);
    end
  endtask

`ifdef EPMP_UART_RX_EN
  task automatic test_rx();
    logic [7:0] r;
    logic [7:0] e;
    int n;
    exp_rx.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    n = 0;
    while (Irq !== 1'b1 && n < 30) begin
      @(negedge clk); n++;
    end
    n_cmp++;
    if (Irq !== 1'b1) begin
      n_err++; $display("FAIL rx_irq: got %b want 1", Irq);
    end
    bus_read(16'hFF01, r);
    n_cmp++;
    if (r !== 8'h06) begin
      n_err++; $display("FAIL rx_status_valid: got %h want 06", r);
    end
    bus_read(16'hFF00, r);
    e = exp_rx.pop_front();
    n_cmp++;
    if (r !== e) begin
      n_err++; $display("FAIL rx_data: got %h want %h", r, e);
    end
    bus_read(16'hFF01, r);
    n_cmp++;
    if (r !== 8'h02) begin
      n_err++; $display("FAIL rx_popped: got %h want 02", r);
    end
  endtask

  task automatic test_rx_errors();
    logic [7:0] r;
    logic [7:0] e;
    exp_rx.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (10) @(negedge clk);
    bus_read(16'hFF01, r);
    n_cmp++;
    if (r !== 8'h0E) begin
      n_err++; $display("FAIL ovr_status: got %h want 0E", r);
    end
    bus_read(16'hFF00, r);
    e = exp_rx.pop_front();
    n_cmp++;
    if (r !== e) begin
      n_err++; $display("FAIL ovr_kept: got %h want %h", r, e);
    end
    exp_rx.push_back(8'h33);
    send_frame(8'h33, 1'b0);
    repeat (10) @(negedge clk);
    bus_read(16'hFF01, r);
    n_cmp++;
    if (r !== 8'h1E) begin
      n_err++; $display("FAIL ferr_status: got %h want 1E", r);
    end
    bus_read(16'hFF00, r);
    e = exp_rx.pop_front();
    n_cmp++;
    if (r !== e) begin
      n_err++; $display("FAIL ferr_data: got %h want %h", r, e);
    end
    bus_write(16'hFF01, 8'h18);
    bus_read(16'hFF01, r);
    n_cmp++;
    if (r !== 8'h02) begin
      n_err++; $display("FAIL err_clear: got %h want 02", r);
    end
    @(negedge clk);
    RxD = 1'b0;
    @(negedge clk);
    RxD = 1'b1;
    repeat (20) @(negedge clk);
    bus_read(16'hFF01, r);
    n_cmp++;
    if (r !== 8'h02) begin
      n_err++; $display("FAIL glitch_status: got %h want 02", r);
    end
  endtask
`else
  task automatic test_rx_disabled();
    logic [7:0] r;
    send_frame(8'h5A, 1'b1);
    repeat (10) @(negedge clk);
    bus_read(16'hFF00, r);
    n_cmp++;
    if (r !== 8'h00) begin
      n_err++; $display("FAIL norx_data: got %h want 00", r);
    end
    bus_read(16'hFF01, r);
    n_cmp++;
    if (r !== 8'h02) begin
      n_err++; $display("FAIL norx_status: got %h want 02", r);
    end
    n_cmp++;
    if (Irq !== 1'b0) begin
      n_err++; $display("FAIL norx_irq: got %b want 0", Irq);
    end
  endtask
`endif

  task automatic test_reset_midframe();
    logic [7:0] r;
    int bad;
    bus_write(16'hFF00, 8'h00);
    repeat (10) @(negedge clk);
    n_cmp++;
    if (TxD !== 1'b0) begin
      n_err++; $display("FAIL mid_txd_busy: got %b want 0", TxD);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (TxD !== 1'b1) begin
      n_err++; $display("FAIL mid_reset_txd: got %b want 1", TxD);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (TxD !== 1'b1) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_err++; $display("FAIL mid_resume: got %0d low cycles want 0", bad);
    end
    bus_read(16'hFF01, r);
    n_cmp++;
    if (r !== 8'h02) begin
      n_err++; $display("FAIL mid_status: got %h want 02", r);
    end
    got_tx.delete();
    got_t.delete();
  endtask

  initial begin
    test_reset();
    test_tx();
    test_back_to_back();
    test_multi_write();
    test_ctrl_irq();
`ifdef EPMP_UART_RX_EN
    test_rx();
    test_rx_errors();
`else
    test_rx_disabled();
`endif
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
